// File: rtl/game_countdown_if.sv
// Control and status bundle for the game countdown timer.
// The master drives the player controls; the slave reports the countdown status.
interface game_countdown_if #(
    parameter int CW = 7
);
    logic [1:0]    max_digit;
    logic          start;
    logic          stop;
    logic          pause;
    logic [CW-1:0] counter;
    logic          tick;
    logic          expired;
    logic          timeout;
    logic          running;
    logic          warn;

    modport master (
        output max_digit, start, stop, pause,
        input  counter, tick, expired, timeout, running, warn
    );

    modport slave (
        input  max_digit, start, stop, pause,
        output counter, tick, expired, timeout, running, warn
    );
endinterface

// File: rtl/game_countdown.sv
// Guessing-game countdown: loads a per-difficulty number of seconds and counts
// them down once every TICK_DIV cycles, with pause, stop and expiry reporting.
module game_countdown #(
    parameter int TICK_DIV = 50000000,
    parameter int CW       = 7,
    parameter int T1       = 30,
    parameter int T2       = 60,
    parameter int T3       = 90,
    parameter int WARN     = 10
) (
    input  logic           clk,
    input  logic           restart,
    game_countdown_if.slave bus
);
    localparam int CMAX = (1 << CW) - 1;
    localparam int PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    if (T1 > CMAX || T2 > CMAX || T3 > CMAX || WARN > CMAX) begin : g_bad_time
        $error("game_countdown: a time parameter does not fit in CW bits");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("game_countdown: TICK_DIV must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] presc_q, presc_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          tick_q, tick_n;
    logic          exp_q, exp_n;
    logic [CW-1:0] load_val;

    function automatic logic [CW-1:0] load_for(input logic [1:0] md);
        case (md)
            2'd1:    return CW'(T1);
            2'd2:    return CW'(T2);
            2'd3:    return CW'(T3);
            default: return '0;
        endcase
    endfunction

    assign load_val = load_for(bus.max_digit);

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_q <= IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            presc_q <= presc_n;
            cnt_q   <= cnt_n;
            tick_q  <= tick_n;
            exp_q   <= exp_n;
        end
    end

    // Event priority: start, then stop, then pause, then the prescaler terminal.
    always_comb begin
        state_n = state_q;
        presc_n = presc_q;
        cnt_n   = cnt_q;
        tick_n  = 1'b0;
        exp_n   = 1'b0;
        if (bus.start) begin
            cnt_n   = load_val;
            presc_n = '0;
            if (load_val != '0) begin
                state_n = RUN;
            end else begin
                state_n = DONE;
                exp_n   = 1'b1;
            end
        end else if (bus.stop && (state_q == RUN || state_q == PAUSE)) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.pause) begin
                        state_n = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_n = '0;
                        tick_n  = 1'b1;
                        if (cnt_q <= CW'(1)) begin
                            cnt_n   = '0;
                            state_n = DONE;
                            exp_n   = 1'b1;
                        end else begin
                            cnt_n = cnt_q - 1'b1;
                        end
                    end else begin
                        presc_n = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        state_n = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.counter = cnt_q;
    assign bus.tick    = tick_q;
    assign bus.expired = exp_q;
    assign bus.timeout = (state_q == DONE);
    assign bus.running = (state_q == RUN);
    assign bus.warn    = (state_q == RUN || state_q == PAUSE) &&
                         (cnt_q != '0) && (cnt_q <= CW'(WARN));
endmodule

// File: tb/tb_game_countdown.sv
// Bench for game_countdown with a fast prescaler: vector table, directed
// corner sequences and randomized play checked against a deadline-based model.
module tb_game_countdown;
    localparam int TD   = 4;
    localparam int CW   = 7;
    localparam int T1   = 30;
    localparam int T2   = 60;
    localparam int T3   = 90;
    localparam int WARN = 10;

    logic clk = 1'b0;
    logic restart;

    game_countdown_if #(.CW(CW)) bus();

    game_countdown #(
        .TICK_DIV(TD), .CW(CW), .T1(T1), .T2(T2), .T3(T3), .WARN(WARN)
    ) dut (
        .clk    (clk),
        .restart(restart),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 run, 2 pause, 3 done. Seconds end at absolute
    // edge numbers; a pause banks the counting edges still owed.
    int m_mode, m_sec, m_now, m_deadline, m_left;
    bit m_tick, m_exp;

    function automatic int load_of(input int md);
        case (md)
            1:       return T1;
            2:       return T2;
            3:       return T3;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sec = 0; m_tick = 1'b0; m_exp = 1'b0;
    endtask

    task automatic model_edge();
        m_now++;
        m_tick = 1'b0;
        m_exp  = 1'b0;
        if (bus.start) begin
            m_sec      = load_of(int'(bus.max_digit));
            m_deadline = m_now + TD;
            if (m_sec > 0) m_mode = 1;
            else begin m_mode = 3; m_exp = 1'b1; end
        end else if (bus.stop && (m_mode == 1 || m_mode == 2)) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (bus.pause) begin
                m_left = m_deadline - m_now + 1;
                m_mode = 2;
            end else if (m_now == m_deadline) begin
                m_sec--;
                m_tick     = 1'b1;
                m_deadline = m_now + TD;
                if (m_sec == 0) begin m_mode = 3; m_exp = 1'b1; end
            end
        end else if (m_mode == 2 && !bus.pause) begin
            m_mode     = 1;
            m_deadline = m_now + m_left;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!restart) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_exp(input string tag, input int cnt, input int tk, input int ex,
                           input int to, input int rn, input int wn);
        cmp({tag, ".counter"}, int'(bus.counter), cnt);
        cmp({tag, ".tick"},    int'(bus.tick),    tk);
        cmp({tag, ".expired"}, int'(bus.expired), ex);
        cmp({tag, ".timeout"}, int'(bus.timeout), to);
        cmp({tag, ".running"}, int'(bus.running), rn);
        cmp({tag, ".warn"},    int'(bus.warn),    wn);
    endtask

    task automatic chk_model(input string tag);
        chk_exp(tag, m_sec, int'(m_tick), int'(m_exp), int'(m_mode == 3), int'(m_mode == 1),
                int'((m_mode == 1 || m_mode == 2) && m_sec > 0 && m_sec <= WARN));
    endtask

    task automatic drive(input bit st, input bit sp, input bit pa, input logic [1:0] md);
        bus.start = st; bus.stop = sp; bus.pause = pa; bus.max_digit = md;
    endtask

    typedef struct packed {
        bit       st;
        bit       sp;
        bit       pa;
        bit [1:0] md;
        int       cnt;
        bit       tk;
        bit       ex;
        bit       to;
        bit       rn;
        bit       wn;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int ticks, exps, first;
        bit pa;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd1, 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 29, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd0, 29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, 60, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd3, 90, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 90, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 90, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 90, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 2'd0, 90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 2'd1, 30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        m_now = 0; m_deadline = 0; m_left = 0;
        model_reset();
        restart = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        #3;
        chk_exp("reset", 0, 0, 0, 0, 0, 0);
        step(); step();
        restart = 1'b1;
        step();
        chk_exp("idle_after_reset", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].md);
            step();
            chk_exp($sformatf("vec%0d", i), tbl[i].cnt, int'(tbl[i].tk), int'(tbl[i].ex),
                    int'(tbl[i].to), int'(tbl[i].rn), int'(tbl[i].wn));
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0);

        // Full easy countdown from 30.
        drive(1'b1, 1'b0, 1'b0, 2'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        chk_exp("cd_start", 30, 0, 0, 0, 1, 0);
        ticks = 0; exps = 0; first = 0;
        for (int n = 1; n <= 121; n++) begin
            step();
            chk_model($sformatf("cd%0d", n));
            if (bus.tick) begin ticks++; if (first == 0) first = n; end
            if (bus.expired) exps++;
            if (n == 4)   cmp("cd_first_tick_counter", int'(bus.counter), 29);
            if (n == 79)  chk_exp("cd_11", 11, 0, 0, 0, 1, 0);
            if (n == 80)  chk_exp("cd_10", 10, 1, 0, 0, 1, 1);
            if (n == 116) chk_exp("cd_1", 1, 1, 0, 0, 1, 1);
            if (n == 120) chk_exp("cd_end", 0, 1, 1, 1, 0, 0);
            if (n == 121) chk_exp("cd_done", 0, 0, 0, 1, 0, 0);
        end
        cmp("cd_first_tick_cycle", first, 4);
        cmp("cd_tick_count", ticks, 30);
        cmp("cd_expired_count", exps, 1);

        // Pause two cycles into a second.
        drive(1'b1, 1'b0, 1'b0, 2'd2);
        step();
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        step(); step();
        cmp("pz_before", int'(bus.counter), 60);
        bus.pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_exp($sformatf("pz_hold%0d", k), 60, 0, 0, 0, 0, 0);
        end
        bus.pause = 1'b0;
        step();
        chk_exp("pz_resume", 60, 0, 0, 0, 1, 0);
        step();
        cmp("pz_resume1_tick", int'(bus.tick), 0);
        step();
        chk_exp("pz_resume2", 59, 1, 0, 0, 1, 0);

        // Stop at 17, then restart on hard.
        drive(1'b1, 1'b0, 1'b0, 2'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 52; k++) step();
        cmp("stop_pre", int'(bus.counter), 17);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk_exp("stop", 17, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step();
        chk_exp("stop_hold", 17, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 2'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        chk_exp("stop_restart", 90, 0, 0, 0, 1, 0);

        // Asynchronous reset in the middle of a run at 45.
        drive(1'b1, 1'b0, 1'b0, 2'd2);
        step();
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 60; k++) step();
        cmp("rst_pre", int'(bus.counter), 45);
        #2 restart = 1'b0;
        #1;
        chk_exp("rst_async", 0, 0, 0, 0, 0, 0);
        step(); step();
        restart = 1'b1;
        step();
        chk_exp("rst_release", 0, 0, 0, 0, 0, 0);
        chk_model("rst_release_model");

        // Randomized play.
        pa = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (m_mode == 0 || m_mode == 3) bus.start = ($urandom_range(19) == 0);
            else bus.start = ($urandom_range(399) == 0);
            bus.stop = ($urandom_range(299) == 0);
            if ($urandom_range(19) == 0) pa = ~pa;
            bus.pause     = pa;
            bus.max_digit = 2'($urandom_range(3));
            step();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per one-second decrement (>=2).
REQ-002 Parameter CW, default 7, width of counter output.
REQ-003 Parameter T1, default 30, seconds loaded for difficulty 1.
REQ-004 Parameter T2, default 60, seconds loaded for difficulty 2.
REQ-005 Parameter T3, default 90, seconds loaded for difficulty 3.
REQ-006 Parameter WARN, default 10, low-time warning threshold in seconds.
REQ-007 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-008 restart  input  1  asynchronous, active-low reset.
REQ-009 max_digit  input  2  difficulty select, sampled only on start.
REQ-010 start  input  1  one-cycle pulse; loads and runs the timer.
REQ-011 stop  input  1  one-cycle pulse; halts the timer and freezes the count (correct guess).
REQ-012 pause  input  1  level; while high, counting SHALL be frozen.
REQ-013 counter  output  CW  remaining seconds.
REQ-014 tick  output  1  one-cycle pulse on each decrement.
REQ-015 expired  output  1  one-cycle pulse when the count reaches 0 by timeout.
REQ-016 timeout  output  1  level; high in DONE.
REQ-017 running  output  1  high in RUN.
REQ-018 warn  output  1  high in RUN or PAUSE while 0 < counter <= WARN.

Function
REQ-019 The block SHALL have a four-state FSM: IDLE, RUN, PAUSE, DONE.
REQ-020 Load value SHALL be T1, T2 or T3 for max_digit 1, 2 or 3, and 0 for max_digit 0.
REQ-021 start SHALL be honoured in every state: counter <= load value and prescaler <= 0 on the next edge. The next state SHALL be RUN if the load value is non-zero; otherwise DONE with expired pulsed on that same edge.
REQ-022 In RUN, the prescaler SHALL count 0..TICK_DIV-1.
REQ-023 When the prescaler is at TICK_DIV-1, the block SHALL, on the next edge: wrap the prescaler to 0, decrement counter by 1, and pulse tick.
REQ-024 A decrement from 1 to 0 SHALL move the FSM to DONE and pulse expired on the same edge as tick.
REQ-025 counter SHALL never underflow; it SHALL hold 0 in DONE.
REQ-026 In RUN, pause high SHALL move the FSM to PAUSE on the next edge. In PAUSE, the prescaler and counter SHALL hold, and no tick SHALL occur.
REQ-027 In PAUSE, pause low SHALL return the FSM to RUN, and the prescaler SHALL resume from its held value.
REQ-028 stop in RUN or PAUSE SHALL move the FSM to IDLE with counter holding its current value and no expired pulse.
REQ-029 stop in IDLE or DONE SHALL be ignored.
REQ-030 Priority on simultaneous events SHALL be start > stop > pause > prescaler terminal.
REQ-031 A decrement that coincides with stop or start SHALL be discarded.
REQ-032 The pause condition SHALL be checked before the terminal count, so pause high in RUN with the prescaler at TICK_DIV-1 SHALL produce no tick.
REQ-033 counter, tick, expired and the FSM state SHALL be registered.
REQ-034 timeout, running and warn SHALL be decoded from registered state only, with no input-to-output combinational path.
REQ-035 Elaboration SHALL fail if T1, T2, T3 or WARN exceeds 2^CW-1, or if TICK_DIV < 2.
REQ-036 The prescaler width SHALL be $clog2(TICK_DIV).

Reset
REQ-037 restart low SHALL immediately, regardless of clk, force state IDLE, prescaler 0, counter 0, and tick, expired, timeout, running and warn all 0.
REQ-038 Deassertion of restart SHALL take effect at the first clk edge after release; no start SHALL be inferred from reset.
REQ-039 restart asserted mid-RUN SHALL abandon the count with no expired pulse.

Verification (TICK_DIV=4, defaults otherwise)
REQ-040 Reset: restart low mid-RUN at counter 45 -> all outputs 0 without waiting for a clk edge; after release, state is IDLE.
REQ-041 Basic countdown: max_digit=1, start -> counter=30 and running=1 next cycle; first tick 4 cycles later with counter=29; 120 cycles after start, counter=0, tick and expired high for exactly 1 cycle, timeout=1.
REQ-042 Pause: in RUN, 2 cycles into a second, pause high for 10 cycles -> counter and tick unchanged throughout; next tick 2 cycles after return to RUN.
REQ-043 Stop: stop at counter=17 -> IDLE next cycle, counter stays 17, no expired pulse; a following start with max_digit=3 -> counter=90.
REQ-044 Collisions: start and stop in the same cycle in PAUSE -> counter reloads and state is RUN. stop on the prescaler terminal cycle -> counter is not decremented.
REQ-045 Boundaries: start with max_digit=0 -> counter=0, expired pulses once, timeout=1. warn rises when counter reaches 10 and falls when counter reaches 0.
